shiftregister_universal: RTL and testbench
==========================================

# shiftregister_universal

Parametrised universal shift register: successor to the fixed 5-bit right-shift JK chain. Supports hold, bidirectional shift, parallel load, synchronous clear and rotate, plus a counted burst mode with busy/done handshake. Used as the serialiser/deserialiser and pattern-rotation stage in later lab experiments.

## Interface

Parameters:
- WIDTH, 5, register length in bits (≥2).
- CW, derived localparam = $clog2(WIDTH+1), width of count (not overridable).

Ports:
- clockpulse  in  1  clock; all state changes on rising edge.
- clear  in  1  reset, asynchronous, active-low; forces every output to its reset value.
- mode  in  3  operation select (see Operation).
- start  in  1  request a counted burst of the shift/rotate in mode.
- count  in  CW  number of shift steps for a burst.
- serialInputRight  in  1  bit entering out[0] on shift right.
- serialInputLeft  in  1  bit entering out[WIDTH-1] on shift left.
- preset  in  WIDTH  parallel-load data.
- out  out  WIDTH  register contents.
- notout  out  WIDTH  bitwise ~out, always.
- serialOutRight  out  1  = out[WIDTH-1].
- serialOutLeft  out  1  = out[0].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after a burst ends.

## Operation

- Mode encoding: 000 hold; 001 shift right (out[i+1]<=out[i], out[0]<=serialInputRight); 010 shift left (out[i]<=out[i+1], out[WIDTH-1]<=serialInputLeft); 011 load out<=preset; 100 synchronous clear out<=0; 101 rotate right (out[0]<=old out[WIDTH-1]); 110 rotate left (out[WIDTH-1]<=old out[0]); 111 reserved = hold.
- "Shift-type" modes: 001, 010, 101, 110.
- FSM, two states:
  - IDLE: each edge executes mode. If start=1 and mode is shift-type and count≠0: register unchanged that edge, latch mode→burstMode, count→remaining, busy<=1, go BURST. If start=1 and count=0 with shift-type mode: no change, done<=1 next cycle, stay IDLE. start with non-shift-type mode: ignored, mode executes normally.
  - BURST: each edge performs burstMode once, remaining<=remaining−1. On the edge where remaining=1: busy<=0, done<=1, go IDLE. mode, start, preset, count ignored; serial inputs sampled live each edge.
- count may exceed WIDTH; shifting simply continues (shift fills with serial input, rotate wraps).
- done is cleared on the next edge regardless of inputs.

## Timing

- Reset (clear=0, asynchronous): out=0, notout=all ones, busy=0, done=0, state=IDLE, remaining=0. Reset mid-burst aborts it with no done pulse.
- Idle-mode latency: one edge; out valid after the edge on which mode is sampled.
- Burst: start sampled at edge E0; shifts at E1..En (n=count); busy high from after E0 through before En; done high for exactly the cycle after En.
- start asserted on the same edge done is high (IDLE): accepted, new burst begins.
- serialOut*, notout combinational from out; no extra latency.

## Configuration

- ROTATOR_MODES_EN defined: modes 101/110 rotate as specified and are accepted for bursts.
- Not defined: 101/110 behave as hold; start with 101/110 is ignored (no busy, no done). All other behaviour identical.

## Test plan

- Reset: clear=0 mid-activity -> out=00000, notout=11111, busy=0, done=0 immediately, without a clock edge.
- Load + shift right, WIDTH=5: mode=011 preset=10110, then mode=001 serialInputRight=1 -> out=10110, then 01101; serialOutRight=0.
- Burst left: out=10110, mode=010 start=1 count=3 serialInputLeft=0 -> unchanged at E0, busy 3 cycles, out=00010 after E3, done high one cycle, busy=0.
- Rotate (macro defined): out=10011, mode=101 -> 00111; mode=110 from 10011 -> 11001. Macro undefined: out stays 10011.
- count=0 burst: start=1 mode=001 count=0 -> out unchanged, busy stays 0, done pulses one cycle.
- Reset mid-burst: count=4 start, assert clear after E2 -> out=0, busy=0, no done; next start runs a full fresh burst.

Source files
------------

// File: rtl/shiftregister_universal.sv
// Parametrised universal shift register: hold/shift/load/clear/rotate plus counted bursts
// with busy/done handshake. Define ROTATOR_MODES_EN to enable the rotate modes 101/110.
module shiftregister_universal #(
    parameter  int WIDTH = 5,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CW-1:0]    count,
    input  logic             serialInputRight,
    input  logic             serialInputLeft,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout,
    output logic             serialOutRight,
    output logic             serialOutLeft,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       burst_mode_q, burst_mode_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Only shift-type modes can be run as a counted burst.
    function automatic logic is_shift_mode(input logic [2:0] m);
`ifdef ROTATOR_MODES_EN
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b101) || (m == 3'b110);
`else
        return (m == 3'b001) || (m == 3'b010);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] next_out(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic             sin_r,
        input logic             sin_l,
        input logic [WIDTH-1:0] load_v
    );
        case (m)
            3'b001:  return {cur[WIDTH-2:0], sin_r};
            3'b010:  return {sin_l, cur[WIDTH-1:1]};
            3'b011:  return load_v;
            3'b100:  return '0;
`ifdef ROTATOR_MODES_EN
            3'b101:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b110:  return {cur[0], cur[WIDTH-1:1]};
`endif
            default: return cur;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        burst_mode_d = burst_mode_q;
        remaining_d  = remaining_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_shift_mode(mode)) begin
                    // A zero-length burst completes immediately with a done pulse.
                    if (count != '0) begin
                        burst_mode_d = mode;
                        remaining_d  = count;
                        busy_d       = 1'b1;
                        state_d      = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    out_d = next_out(mode, out_q, serialInputRight, serialInputLeft, preset);
                end
            end
            BURST: begin
                out_d       = next_out(burst_mode_q, out_q, serialInputRight, serialInputLeft, preset);
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state_q      <= IDLE;
            out_q        <= '0;
            burst_mode_q <= 3'b000;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            burst_mode_q <= burst_mode_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign out            = out_q;
    assign notout         = ~out_q;
    assign serialOutRight = out_q[WIDTH-1];
    assign serialOutLeft  = out_q[0];
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_shiftregister_universal.sv
// Randomised bench for shiftregister_universal against an arithmetic reference model,
// plus directed checks of the documented scenarios.
module tb_shiftregister_universal;

    localparam int W  = 5;
    localparam int CW = $clog2(W + 1);

    logic          clockpulse = 1'b0;
    logic          clear;
    logic [2:0]    mode;
    logic          start;
    logic [CW-1:0] count;
    logic          serialInputRight;
    logic          serialInputLeft;
    logic [W-1:0]  preset;
    logic [W-1:0]  out;
    logic [W-1:0]  notout;
    logic          serialOutRight;
    logic          serialOutLeft;
    logic          busy;
    logic          done;

    shiftregister_universal #(.WIDTH(W)) dut (
        .clockpulse      (clockpulse),
        .clear           (clear),
        .mode            (mode),
        .start           (start),
        .count           (count),
        .serialInputRight(serialInputRight),
        .serialInputLeft (serialInputLeft),
        .preset          (preset),
        .out             (out),
        .notout          (notout),
        .serialOutRight  (serialOutRight),
        .serialOutLeft   (serialOutLeft),
        .busy            (busy),
        .done            (done)
    );

    always #5 clockpulse = ~clockpulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: register value as an integer, burst bookkeeping as counters.
    int m_out, m_busy, m_done, m_rem, m_mode;

    function automatic bit model_shift_type(input int md);
`ifdef ROTATOR_MODES_EN
        return md == 1 || md == 2 || md == 5 || md == 6;
`else
        return md == 1 || md == 2;
`endif
    endfunction

    function automatic int model_apply(input int md, input int v, input int r, input int l, input int p);
        int mask;
        mask = (1 << W) - 1;
        case (md)
            1: return ((v << 1) | r) & mask;
            2: return (v >> 1) | (l << (W - 1));
            3: return p & mask;
            4: return 0;
`ifdef ROTATOR_MODES_EN
            5: return ((v << 1) | (v >> (W - 1))) & mask;
            6: return (v >> 1) | ((v & 1) << (W - 1));
`endif
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0;
    endtask

    task automatic model_edge();
        int sr, sl;
        sr = int'(serialInputRight);
        sl = int'(serialInputLeft);
        if (m_busy != 0) begin
            m_out = model_apply(m_mode, m_out, sr, sl, int'(preset));
            m_rem = m_rem - 1;
            m_done = (m_rem == 0) ? 1 : 0;
            if (m_rem == 0) m_busy = 0;
        end else begin
            m_done = 0;
            if (start && model_shift_type(int'(mode))) begin
                if (count != 0) begin
                    m_busy = 1;
                    m_rem  = int'(count);
                    m_mode = int'(mode);
                end else begin
                    m_done = 1;
                end
            end else begin
                m_out = model_apply(int'(mode), m_out, sr, sl, int'(preset));
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int mask;
        mask = (1 << W) - 1;
        check_eq("out",     32'(out),            32'(m_out));
        check_eq("notout",  32'(notout),         32'((~m_out) & mask));
        check_eq("sor",     32'(serialOutRight), 32'((m_out >> (W - 1)) & 1));
        check_eq("sol",     32'(serialOutLeft),  32'(m_out & 1));
        check_eq("busy",    32'(busy),           32'(m_busy));
        check_eq("done",    32'(done),           32'(m_done));
    endtask

    // Inputs change at the falling edge; model advances at the rising edge.
    task automatic step();
        @(posedge clockpulse);
        model_edge();
        @(negedge clockpulse);
        check_all();
    endtask

    task automatic do_reset();
        #2;
        clear = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clockpulse);
        check_all();
        clear = 1'b1;
    endtask

    task automatic set_idle();
        mode = 3'b000; start = 1'b0; count = '0;
        serialInputRight = 1'b0; serialInputLeft = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        set_idle();
        mode = 3'b011; preset = v;
        step();
        check_eq("load_val", 32'(out), 32'(v));
    endtask

    initial begin
        clear = 1'b0;
        preset = '0;
        set_idle();
        model_reset();
        #1;
        check_all();
        @(negedge clockpulse);
        clear = 1'b1;

        // Load then shift right.
        load(5'b10110);
        mode = 3'b001; serialInputRight = 1'b1;
        step();
        check_eq("shr_val", 32'(out), 32'(5'b01101));
        check_eq("shr_sor", 32'(serialOutRight), 32'(0));

        // Burst left of three.
        load(5'b10110);
        mode = 3'b010; start = 1'b1; count = 3'd3; serialInputLeft = 1'b0;
        step();
        check_eq("burst_e0", 32'(out), 32'(5'b10110));
        check_eq("burst_busy", 32'(busy), 32'(1));
        mode = 3'b011; start = 1'b0; preset = 5'b11111;
        step();
        step();
        step();
        check_eq("burst_end", 32'(out), 32'(5'b00010));
        check_eq("burst_done", 32'(done), 32'(1));
        check_eq("burst_idle", 32'(busy), 32'(0));
        set_idle();
        step();
        check_eq("done_clr", 32'(done), 32'(0));

        // Rotate right and left.
        load(5'b10011);
        mode = 3'b101;
        step();
`ifdef ROTATOR_MODES_EN
        check_eq("rotr", 32'(out), 32'(5'b00111));
`else
        check_eq("rotr", 32'(out), 32'(5'b10011));
`endif
        load(5'b10011);
        mode = 3'b110;
        step();
`ifdef ROTATOR_MODES_EN
        check_eq("rotl", 32'(out), 32'(5'b11001));
`else
        check_eq("rotl", 32'(out), 32'(5'b10011));
`endif

        // Zero-length burst.
        load(5'b01010);
        mode = 3'b001; start = 1'b1; count = '0;
        step();
        check_eq("cnt0_out", 32'(out), 32'(5'b01010));
        check_eq("cnt0_done", 32'(done), 32'(1));
        set_idle();
        step();

        // Reset mid-burst, then a fresh full burst.
        load(5'b11111);
        mode = 3'b001; start = 1'b1; count = 3'd4;
        step();
        start = 1'b0;
        step();
        step();
        do_reset();
        check_eq("rst_out", 32'(out), 32'(0));
        set_idle();
        step();
        check_eq("rst_nodone", 32'(done), 32'(0));
        mode = 3'b010; start = 1'b1; count = 3'd4; serialInputLeft = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_eq("fresh_out", 32'(out), 32'(5'b11110));
        check_eq("fresh_done", 32'(done), 32'(1));

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            mode             = 3'($urandom_range(0, 7));
            start            = ($urandom_range(0, 3) == 0);
            count            = CW'($urandom_range(0, (1 << CW) - 1));
            serialInputRight = 1'($urandom);
            serialInputLeft  = 1'($urandom);
            preset           = W'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
